// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with write FIFO, runtime baud divider, parity and stop-bit select.
// Configuration is captured at every frame start and held until the frame ends.
module uart_tx_fifo_cfg #(
    parameter int SIZE_DATA   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int OVER_SAMPLE = 16,
    parameter int SIZE_BAUD   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [SIZE_BAUD-1:0]          i_baud_div,
    input  logic [1:0]                    i_parity_mode,
    input  logic                          i_stop2,
    input  logic                          i_wr_en,
    input  logic [SIZE_DATA-1:0]          i_wr_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow,
    output logic                          o_busy,
    output logic                          o_tx_serial,
    output logic                          o_tx_done
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int OSW = (OVER_SAMPLE > 1) ? $clog2(OVER_SAMPLE) : 1;
    localparam int BW  = $clog2(SIZE_DATA);

    localparam logic [OSW-1:0] OS_LAST  = OSW'(OVER_SAMPLE - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(SIZE_DATA - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [SIZE_DATA-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 full_q, empty_q, ovf_q;
    logic                 wr_ok, pop, load;

    state_t               state_q, state_d;
    logic [SIZE_BAUD-1:0] baud_q, baud_d;
    logic [SIZE_BAUD-1:0] div_q, div_d;
    logic [OSW-1:0]       os_q, os_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [SIZE_DATA-1:0] sh_q, sh_d, head;
    logic                 par_q, par_d;
    logic                 par_on_q, par_on_d;
    logic                 stop2_q, stop2_d;
    logic                 tick, bit_end, tx, done;

    assign wr_ok   = i_wr_en && !full_q;
    assign head    = mem_q[rd_ptr_q];
    assign tick    = (baud_q == div_q);
    assign bit_end = tick && (os_q == OS_LAST);

    always_comb begin
        count_d = count_q;
        unique case ({wr_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CW'(FIFO_DEPTH));
            empty_q <= (count_d == '0);
            ovf_q   <= i_wr_en && full_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = tick ? '0 : baud_q + 1'b1;
        os_d     = os_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        par_d    = par_q;
        div_d    = div_q;
        par_on_d = par_on_q;
        stop2_d  = stop2_q;
        load     = 1'b0;
        pop      = 1'b0;
        tx       = 1'b1;
        done     = 1'b0;
        if (tick) os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                os_d   = '0;
                load   = !empty_q;
            end
            START: begin
                tx = 1'b0;
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                tx = sh_q[0];
                if (bit_end) begin
                    sh_d = sh_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = par_on_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                tx = par_q;
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == BW'(stop2_q)) begin
                        done    = 1'b1;
                        bit_d   = '0;
                        state_d = IDLE;
                        load    = !empty_q;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Popping in the last stop clock chains frames with no idle gap.
        if (load) begin
            pop      = 1'b1;
            state_d  = START;
            baud_d   = '0;
            os_d     = '0;
            bit_d    = '0;
            sh_d     = head;
            div_d    = i_baud_div;
            par_on_d = ^i_parity_mode;
            stop2_d  = i_stop2;
            par_d    = (^head) ^ (i_parity_mode == 2'b10);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            div_q    <= '0;
            os_q     <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            par_on_q <= 1'b0;
            stop2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            div_q    <= div_d;
            os_q     <= os_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            par_on_q <= par_on_d;
            stop2_q  <= stop2_d;
        end
    end

    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_count     = count_q;
    assign o_overflow  = ovf_q;
    assign o_busy      = (state_q != IDLE);
    assign o_tx_serial = tx;
    assign o_tx_done   = done;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Scenario tests for uart_tx_fifo_cfg; a line monitor decodes frames
// and compares them against a queue of words written by the tests.
module tb_uart_tx_fifo_cfg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = '0;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop2 = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        full, empty, ovf, busy, tx, done;
    logic [4:0]  count;

    int checks = 0;
    int failures = 0;
    int m_frames = 0;

    typedef struct packed {
        logic [7:0]  data;
        logic [1:0]  pmode;
        logic        stop2;
        logic        par;
        logic [15:0] div;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_fifo_cfg dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_baud_div    (baud_div),
        .i_parity_mode (parity_mode),
        .i_stop2       (stop2),
        .i_wr_en       (wr_en),
        .i_wr_data     (wr_data),
        .o_full        (full),
        .o_empty       (empty),
        .o_count       (count),
        .o_overflow    (ovf),
        .o_busy        (busy),
        .o_tx_serial   (tx),
        .o_tx_done     (done)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [7:0] d, input logic [15:0] dv);
        exp_t e;
        e.data  = d;
        e.pmode = parity_mode;
        e.stop2 = stop2;
        e.par   = (^d) ^ (parity_mode == 2'b10);
        e.div   = dv;
        exp_q.push_back(e);
    endtask

    task automatic wait_n(input int n, output bit ab);
        ab = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (rst) begin
                ab = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_idle(input int bound, output bit to);
        to = 1'b1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && empty) begin
                to = 1'b0;
                return;
            end
        end
    endtask

    exp_t       m_e;
    bit         m_ab;
    int         m_len;
    logic [7:0] m_got;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected_frame got=start_bit required=no_frame");
                    m_e = '0;
                    m_e.div = baud_div;
                end else begin
                    m_e = exp_q.pop_front();
                end
                m_len = 16 * (int'(m_e.div) + 1);
                wait_n(m_len / 2, m_ab);
                if (!m_ab) begin
                    checks++;
                    if (tx !== 1'b0) begin
                        failures++;
                        $display("FAIL mon_start got=%b required=0", tx);
                    end
                end
                for (int i = 0; i < 8; i++) begin
                    if (!m_ab) wait_n(m_len, m_ab);
                    if (!m_ab) m_got[i] = tx;
                end
                if (!m_ab && (m_e.pmode == 2'b01 || m_e.pmode == 2'b10)) begin
                    wait_n(m_len, m_ab);
                    if (!m_ab) begin
                        checks++;
                        if (tx !== m_e.par) begin
                            failures++;
                            $display("FAIL mon_parity got=%b required=%b", tx, m_e.par);
                        end
                    end
                end
                for (int s = 0; s < (m_e.stop2 ? 2 : 1); s++) begin
                    if (!m_ab) wait_n(m_len, m_ab);
                    if (!m_ab) begin
                        checks++;
                        if (tx !== 1'b1) begin
                            failures++;
                            $display("FAIL mon_stop got=%b required=1", tx);
                        end
                    end
                end
                if (!m_ab) wait_n(m_len / 2 - 1, m_ab);
                if (!m_ab) begin
                    m_frames++;
                    checks++;
                    if (m_got !== m_e.data) begin
                        failures++;
                        $display("FAIL mon_data got=%h required=%h", m_got, m_e.data);
                    end
                end
                while (rst) @(negedge clk);
            end
        end
    end

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, empty, full, count, ovf, busy, done} !== {1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%b%b%b_%0d_%b%b%b required=110_0_000",
                     tx, empty, full, count, ovf, busy, done);
        end
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int done_c, ndone;
        bit to;
        done_c = -1;
        ndone  = 0;
        baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hA5; push(8'hA5, 16'd0);
        for (int c = 1; c <= 170; c++) begin
            @(negedge clk);
            if (c == 1) begin
                wr_en = 1'b0;
                checks++;
                if ({empty, tx, count} !== {1'b0, 1'b1, 5'd1}) begin
                    failures++;
                    $display("FAIL basic_c1 got=e%b_tx%b_n%0d required=e0_tx1_n1", empty, tx, count);
                end
            end
            if (c == 2 || c == 17) begin
                checks++;
                if ({tx, busy} !== 2'b01) begin
                    failures++;
                    $display("FAIL basic_start_c%0d got=tx%b_b%b required=tx0_b1", c, tx, busy);
                end
            end
            if (c == 18) begin
                checks++;
                if (tx !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_bit0 got=%b required=1", tx);
                end
            end
            if (done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
            if (c == 162) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_busy_fall got=%b required=0", busy);
                end
            end
        end
        checks++;
        if (done_c != 161 || ndone != 1) begin
            failures++;
            $display("FAIL basic_done got=c%0d_n%0d required=c161_n1", done_c, ndone);
        end
        wait_idle(200, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL basic_drain got=timeout required=idle");
        end
    endtask

    task automatic test_parity(input logic [1:0] pm, input logic exp_par);
        int done_c;
        bit to;
        done_c = -1;
        baud_div = 16'd2; parity_mode = pm; stop2 = 1'b1;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h07; push(8'h07, 16'd2);
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (c == 1) wr_en = 1'b0;
            if (c == 458) begin
                checks++;
                if (tx !== exp_par) begin
                    failures++;
                    $display("FAIL parity_bit_m%0d got=%b required=%b", pm, tx, exp_par);
                end
            end
            if (c == 554) begin
                checks++;
                if (tx !== 1'b1) begin
                    failures++;
                    $display("FAIL parity_stop2_m%0d got=%b required=1", pm, tx);
                end
            end
            if (done && done_c < 0) done_c = c;
        end
        checks++;
        if (done_c != 577) begin
            failures++;
            $display("FAIL parity_len_m%0d got=%0d required=577", pm, done_c);
        end
        wait_idle(200, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL parity_drain got=timeout required=idle");
        end
        baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b0;
    endtask

    task automatic test_back_to_back;
        int dc[3];
        int nd;
        bit to;
        logic [7:0] w[3];
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
        nd = 0;
        dc[0] = -1; dc[1] = -1; dc[2] = -1;
        baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_data = w[0]; push(w[0], 16'd0);
        for (int c = 1; c <= 500; c++) begin
            @(negedge clk);
            if (c <= 2) begin
                wr_data = w[c]; push(w[c], 16'd0);
            end
            if (c == 3) wr_en = 1'b0;
            if (done) begin
                if (nd < 3) dc[nd] = c;
                nd++;
            end
            if (c == 1 || c == 3 || c == 161 || c == 162 || c == 322) begin
                int req;
                req = (c == 1 || c == 162) ? 1 : (c == 322) ? 0 : 2;
                checks++;
                if (int'(count) != req) begin
                    failures++;
                    $display("FAIL b2b_count_c%0d got=%0d required=%0d", c, count, req);
                end
            end
            if (c == 162 || c == 322) begin
                checks++;
                if ({tx, busy} !== 2'b01) begin
                    failures++;
                    $display("FAIL b2b_gap_c%0d got=tx%b_b%b required=tx0_b1", c, tx, busy);
                end
            end
        end
        checks++;
        if (nd != 3 || dc[0] != 161 || dc[1] != 321 || dc[2] != 481) begin
            failures++;
            $display("FAIL b2b_done got=%0d,%0d,%0d_n%0d required=161,321,481_n3",
                     dc[0], dc[1], dc[2], nd);
        end
        wait_idle(200, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL b2b_drain got=timeout required=idle");
        end
    endtask

    task automatic test_overflow;
        int f0;
        bit to;
        logic [7:0] d;
        f0 = m_frames;
        baud_div = 16'd1; parity_mode = 2'b00; stop2 = 1'b0;
        @(negedge clk);
        d = 8'($urandom);
        wr_en = 1'b1; wr_data = d; push(d, 16'd1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c <= 17) begin
                d = 8'($urandom);
                wr_data = d;
                if (c <= 16) push(d, 16'd1);
            end
            if (c == 18) wr_en = 1'b0;
            if (c == 16) begin
                checks++;
                if ({full, count} !== {1'b0, 5'd15}) begin
                    failures++;
                    $display("FAIL ovf_c16 got=f%b_n%0d required=f0_n15", full, count);
                end
            end
            if (c == 17) begin
                checks++;
                if ({full, count, ovf} !== {1'b1, 5'd16, 1'b0}) begin
                    failures++;
                    $display("FAIL ovf_full got=f%b_n%0d_o%b required=f1_n16_o0", full, count, ovf);
                end
            end
            if (c == 18 || c == 19) begin
                checks++;
                if ({ovf, count} !== {(c == 18), 5'd16}) begin
                    failures++;
                    $display("FAIL ovf_pulse_c%0d got=o%b_n%0d required=o%0d_n16", c, ovf, count, c == 18);
                end
            end
        end
        wait_idle(6000, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL ovf_drain got=timeout required=idle");
        end
        repeat (400) @(negedge clk);
        checks++;
        if (m_frames - f0 != 17 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovf_frames got=%0d_b%b required=17_b0", m_frames - f0, busy);
        end
        baud_div = 16'd0;
    endtask

    task automatic test_cfg_midframe;
        int dc[2];
        int nd;
        bit to;
        nd = 0;
        dc[0] = -1; dc[1] = -1;
        baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h3C; push(8'h3C, 16'd0);
        for (int c = 1; c <= 820; c++) begin
            @(negedge clk);
            if (c == 1) begin
                wr_data = 8'h01; push(8'h01, 16'd3);
            end
            if (c == 2) wr_en = 1'b0;
            if (c == 60) baud_div = 16'd3;
            if (done) begin
                if (nd < 2) dc[nd] = c;
                nd++;
            end
            if (c == 225 || c == 226) begin
                checks++;
                if (tx !== (c == 226)) begin
                    failures++;
                    $display("FAIL cfg_bit_edge_c%0d got=%b required=%0d", c, tx, c == 226);
                end
            end
        end
        checks++;
        if (nd != 2 || dc[0] != 161 || dc[1] != 801) begin
            failures++;
            $display("FAIL cfg_done got=%0d,%0d_n%0d required=161,801_n2", dc[0], dc[1], nd);
        end
        wait_idle(200, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL cfg_drain got=timeout required=idle");
        end
        baud_div = 16'd0;
    endtask

    task automatic test_reset_midframe;
        int nd, done_c;
        bit to;
        nd = 0;
        done_c = -1;
        baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h5A; push(8'h5A, 16'd0);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) begin
                wr_data = 8'h3C; push(8'h3C, 16'd0);
            end
            if (c == 2) wr_en = 1'b0;
            if (done) nd++;
            if (c == 70) begin
                checks++;
                if ({empty, busy} !== 2'b01) begin
                    failures++;
                    $display("FAIL rstmid_pre got=e%b_b%b required=e0_b1", empty, busy);
                end
                #1 rst = 1'b1;
                #1;
                checks++;
                if ({tx, empty, busy, count, done} !== {1'b1, 1'b1, 1'b0, 5'd0, 1'b0}) begin
                    failures++;
                    $display("FAIL rstmid_now got=tx%b_e%b_b%b_n%0d_d%b required=tx1_e1_b0_n0_d0",
                             tx, empty, busy, count, done);
                end
                exp_q.delete();
            end
            if (c == 75) #1 rst = 1'b0;
        end
        checks++;
        if (nd != 0) begin
            failures++;
            $display("FAIL rstmid_nodone got=%0d required=0", nd);
        end
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hC3; push(8'hC3, 16'd0);
        for (int c = 1; c <= 170; c++) begin
            @(negedge clk);
            if (c == 1) wr_en = 1'b0;
            if (done && done_c < 0) done_c = c;
        end
        checks++;
        if (done_c != 161) begin
            failures++;
            $display("FAIL rstmid_after got=%0d required=161", done_c);
        end
        wait_idle(200, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL rstmid_drain got=timeout required=idle");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity(2'b01, 1'b1);
        test_parity(2'b10, 1'b0);
        test_back_to_back();
        test_overflow();
        test_cfg_midframe();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
